alu_mdu: RTL and testbench

Parametrised, handshaked execute unit for the SimpleCPU EX stage. It extends the single-cycle integer ALU operation set with iterative multiply, divide and remainder. It accepts one operation at a time through a valid/ready input, and holds the result on a valid/ready output until the pipeline consumes it. The EX stage stalls on `in_ready`/`out_valid` and uses `flush` to cancel work on exceptions or branch mispredicts.

---
 rtl/alu_mdu.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_alu_mdu.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu -- execute unit for the SimpleCPU EX stage.
//
// Single-cycle integer ALU ops plus iterative multiply (shift-add) and
// divide/remainder (restoring). Both iterative paths handle one bit per cycle.
// One operation is in flight at a time. It is accepted through a valid/ready
// input and held on a valid/ready output until the pipeline consumes it.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       synchronous, active-high reset
//   flush       cancels the in-flight or held operation, blocks acceptance
//   in_valid    operation request
//   in_ready    unit can accept this cycle (combinational, independent of in_valid)
//   in_op       5-bit opcode
//   in_src1     operand 1 (rj)
//   in_src2     operand 2 (rk / immediate)
//   out_valid   result available
//   out_ready   consumer takes the result
//   out_result  result
//   out_dbz     divide/remainder had a zero divisor
// -----------------------------------------------------------------------------
module alu_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_op,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_dbz
);

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_SLT   = 5'd2;
   localparam logic [4:0] OP_SLTU  = 5'd3;
   localparam logic [4:0] OP_AND   = 5'd4;
   localparam logic [4:0] OP_NOR   = 5'd5;
   localparam logic [4:0] OP_OR    = 5'd6;
   localparam logic [4:0] OP_XOR   = 5'd7;
   localparam logic [4:0] OP_SLL   = 5'd8;
   localparam logic [4:0] OP_SRL   = 5'd9;
   localparam logic [4:0] OP_SRA   = 5'd10;
   localparam logic [4:0] OP_LUI   = 5'd11;
   localparam logic [4:0] OP_MUL   = 5'd12;
   localparam logic [4:0] OP_MULH  = 5'd13;
   localparam logic [4:0] OP_MULHU = 5'd14;
   localparam logic [4:0] OP_DIV   = 5'd15;
   localparam logic [4:0] OP_MOD   = 5'd16;
   localparam logic [4:0] OP_DIVU  = 5'd17;
   localparam logic [4:0] OP_MODU  = 5'd18;

   // Counter must be able to hold WIDTH itself, hence one extra bit.
   localparam int            CNT_W    = SHW + 1;
   localparam logic [SHW:0]  CNT_INIT = CNT_W'(WIDTH);
   localparam logic [SHW:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [4:0]           op_q, op_d;
   logic [WIDTH-1:0]     src1_q, src1_d;     // raw dividend, returned as remainder on divide-by-zero
   logic [WIDTH-1:0]     mcand_q, mcand_d;   // multiplicand magnitude or divisor magnitude
   logic [2*WIDTH-1:0]   prod_q, prod_d;     // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
   logic [SHW:0]         cnt_q, cnt_d;
   logic                 neg_q, neg_d;       // negate product / quotient at the end
   logic                 neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 dbz_q, dbz_d;

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   logic accept;

   assign in_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign accept     = in_valid & in_ready & ~flush;
   assign out_valid  = (state_q == S_DONE);
   assign out_result = result_q;
   assign out_dbz    = dbz_q;

   // ---------------------------------------------------------------------------
   // Operation decode at the input
   // ---------------------------------------------------------------------------
   logic             is_iter_in;
   logic             is_div_in;
   logic             sgn_in;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [SHW-1:0]   shamt;

   assign is_iter_in = (in_op >= OP_MUL) && (in_op <= OP_MODU);
   assign is_div_in  = (in_op >= OP_DIV) && (in_op <= OP_MODU);
   // MUL keeps only the low half, which is identical for signed and unsigned.
   assign sgn_in     = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_MOD);
   assign a_neg      = sgn_in & in_src1[WIDTH-1];
   assign b_neg      = sgn_in & in_src2[WIDTH-1];
   assign a_mag      = a_neg ? (-in_src1) : in_src1;
   assign b_mag      = b_neg ? (-in_src2) : in_src2;
   assign shamt      = in_src2[SHW-1:0];

   // ---------------------------------------------------------------------------
   // Single-cycle ALU (reserved opcodes fall to zero)
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] simple_res;

   always_comb begin
      simple_res = '0;
      case (in_op)
         OP_ADD:  simple_res = in_src1 + in_src2;
         OP_SUB:  simple_res = in_src1 - in_src2;
         OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(in_src1) < $signed(in_src2))};
         OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (in_src1 < in_src2)};
         OP_AND:  simple_res = in_src1 & in_src2;
         OP_NOR:  simple_res = ~(in_src1 | in_src2);
         OP_OR:   simple_res = in_src1 | in_src2;
         OP_XOR:  simple_res = in_src1 ^ in_src2;
         OP_SLL:  simple_res = in_src1 << shamt;
         OP_SRL:  simple_res = in_src1 >> shamt;
         OP_SRA:  simple_res = $signed(in_src1) >>> shamt;
         OP_LUI:  simple_res = in_src2;
         default: simple_res = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Iterative datapath: one step per BUSY cycle
   // ---------------------------------------------------------------------------
   logic                 op_is_div;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_tmp;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_diff;
   logic [WIDTH-1:0]     rem_new;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   step_next;

   assign op_is_div = (op_q >= OP_DIV);

   // Shift-add: add the multiplicand into the upper half when the current
   // multiplier LSB is set, then shift the whole product (with carry) right.
   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

   // Restoring divide: shift the next dividend bit into the partial remainder
   // and subtract the divisor when it fits. The true difference is always
   // below 2^WIDTH when it fits, so a WIDTH-bit subtraction is exact.
   assign div_tmp  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
   assign div_ge   = (div_tmp >= {1'b0, mcand_q});
   assign div_diff = div_tmp[WIDTH-1:0] - mcand_q;
   assign rem_new  = div_ge ? div_diff : div_tmp[WIDTH-1:0];
   assign div_next = {rem_new, prod_q[WIDTH-2:0], div_ge};

   assign step_next = op_is_div ? div_next : mul_next;

   // Sign fix-up applied to the outcome of the final step.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   final_res;

   assign prod_fix = neg_q ? (-step_next) : step_next;
   assign quot     = step_next[WIDTH-1:0];
   assign rem      = step_next[2*WIDTH-1:WIDTH];

   always_comb begin
      final_res = '0;
      case (op_q)
         OP_MUL:           final_res = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:  final_res = dbz_q ? '1 : (neg_q ? (-quot) : quot);
         OP_MOD, OP_MODU:  final_res = dbz_q ? src1_q : (neg_rem_q ? (-rem) : rem);
         default:          final_res = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      src1_d    = src1_q;
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      dbz_d     = dbz_q;

      if (flush) begin
         // Discard whatever was in flight or held; accept is already blocked.
         state_d  = S_IDLE;
         cnt_d    = '0;
         result_d = '0;
         dbz_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end
            S_BUSY: begin
               prod_d = step_next;
               cnt_d  = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d  = S_DONE;
                  result_d = final_res;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase

         // Accept only happens from IDLE or a consumed DONE, so it overrides.
         if (accept) begin
            op_d   = in_op;
            src1_d = in_src1;
            if (is_iter_in) begin
               state_d   = S_BUSY;
               cnt_d     = CNT_INIT;
               neg_d     = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dbz_d     = is_div_in && (in_src2 == '0);
               if (is_div_in) begin
                  mcand_d = b_mag;
                  prod_d  = {{WIDTH{1'b0}}, a_mag};
               end else begin
                  mcand_d = a_mag;
                  prod_d  = {{WIDTH{1'b0}}, b_mag};
               end
            end else begin
               state_d  = S_DONE;
               result_d = simple_res;
               dbz_d    = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         src1_q    <= '0;
         mcand_q   <= '0;
         prod_q    <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         src1_q    <= src1_d;
         mcand_q   <= mcand_d;
         prod_q    <= prod_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         dbz_q     <= dbz_d;
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu -- directed-vector bench for alu_mdu (WIDTH = 32).
// A cycle-level reference model predicts out_valid/in_ready/result from the
// arithmetic definition of each op and its documented latency; a compare
// process checks the DUT against it every cycle. Directed tests also check
// hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_op;
   logic [W-1:0]  in_src1;
   logic [W-1:0]  in_src2;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_result;
   logic          out_dbz;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_dbz    (out_dbz)
   );

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: returns {dbz, result}.
   function automatic logic [32:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      logic [31:0] r;
      logic        z;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      z  = 1'b0;
      p  = '0;
      case (op)
         5'd0:  r = a + b;
         5'd1:  r = a - b;
         5'd2:  r = {31'b0, ($signed(a) < $signed(b))};
         5'd3:  r = {31'b0, (a < b)};
         5'd4:  r = a & b;
         5'd5:  r = ~(a | b);
         5'd6:  r = a | b;
         5'd7:  r = a ^ b;
         5'd8:  r = a << b[4:0];
         5'd9:  r = a >> b[4:0];
         5'd10: r = $signed(a) >>> b[4:0];
         5'd11: r = b;
         5'd12: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
         5'd13: begin p = sa * sb; r = p[63:32]; end
         5'd14: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         5'd15: begin
            if (b == 0) begin r = '1; z = 1'b1; end
            else begin p = sa / sb; r = p[31:0]; end
         end
         5'd16: begin
            if (b == 0) begin r = a; z = 1'b1; end
            else begin p = sa % sb; r = p[31:0]; end
         end
         5'd17: begin
            if (b == 0) begin r = '1; z = 1'b1; end
            else r = a / b;
         end
         5'd18: begin
            if (b == 0) begin r = a; z = 1'b1; end
            else r = a % b;
         end
         default: r = '0;
      endcase
      return {z, r};
   endfunction

   // Cycle-level model: a result appears 1 cycle after accept (simple) or
   // W+1 cycles after accept (iterative) and is held until consumed.
   bit          m_valid = 1'b0;
   bit          m_pend  = 1'b0;
   int          m_left  = 0;
   logic [31:0] m_res   = '0;
   logic        m_dbz   = 1'b0;
   logic [31:0] m_pres  = '0;
   logic        m_pdbz  = 1'b0;

   initial begin : model_proc
      logic [32:0] r;
      bit          rdy;
      forever begin
         @(posedge clk);
         if (reset || flush) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_left  = 0;
         end else begin
            rdy = !m_pend && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_pend) begin
               m_left--;
               if (m_left == 0) begin
                  m_pend  = 1'b0;
                  m_valid = 1'b1;
                  m_res   = m_pres;
                  m_dbz   = m_pdbz;
               end
            end
            if (in_valid && rdy) begin
               r = ref_op(in_op, in_src1, in_src2);
               if (in_op >= 5'd12 && in_op <= 5'd18) begin
                  m_pend = 1'b1;
                  m_left = W;
                  m_pres = r[31:0];
                  m_pdbz = r[32];
               end else begin
                  m_valid = 1'b1;
                  m_res   = r[31:0];
                  m_dbz   = r[32];
               end
            end
         end
      end
   end

   // Every-cycle compare against the model, away from the active edge.
   initial begin : compare_proc
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("model out_valid", 32'(out_valid), 32'(m_valid));
            chk("model in_ready", 32'(in_ready), 32'(!m_pend && (!m_valid || out_ready)));
            if (m_valid) begin
               chk("model out_result", out_result, m_res);
               chk("model out_dbz", 32'(out_dbz), 32'(m_dbz));
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        dbz;
   } vec_t;

   localparam int NV = 24;
   vec_t vt [NV] = '{
      '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0},
      '{5'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0},
      '{5'd2,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0},
      '{5'd3,  32'h80000000, 32'h00000001, 32'h00000000, 1'b0},
      '{5'd5,  32'h0F0F0000, 32'h00F0000F, 32'hF000FFF0, 1'b0},
      '{5'd8,  32'h00000001, 32'h00000024, 32'h00000010, 1'b0},
      '{5'd10, 32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 1'b0},
      '{5'd9,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0},
      '{5'd11, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 1'b0},
      '{5'd25, 32'h00000012, 32'h00000034, 32'h00000000, 1'b0},
      '{5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0},
      '{5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},
      '{5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
      '{5'd13, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b0},
      '{5'd15, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},
      '{5'd16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0},
      '{5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0},
      '{5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0},
      '{5'd17, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1},
      '{5'd18, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1},
      '{5'd15, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b1},
      '{5'd16, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b1},
      '{5'd17, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0},
      '{5'd18, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0}
   };

   // Entered and left just after a rising edge; out_ready is assumed high.
   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_dbz);
      int lat;
      int exp_lat;
      bit got;
      exp_lat = (op >= 5'd12 && op <= 5'd18) ? (W + 1) : 1;
      in_valid = 1'b1;
      in_op    = op;
      in_src1  = a;
      in_src2  = b;
      @(posedge clk);
      #1;
      // Operands must have been captured; scramble the inputs.
      in_valid = 1'b0;
      in_op    = 5'd1;
      in_src1  = $urandom;
      in_src2  = $urandom;
      lat = 1;
      got = 1'b0;
      while (!got && lat <= 100) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
         else begin
            @(posedge clk);
            #1;
            lat++;
         end
      end
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      chk({name, " result"}, out_result, exp_res);
      chk({name, " dbz"}, 32'(out_dbz), 32'(exp_dbz));
      @(posedge clk);
      #1;
      $display("op=%0d a=%08h b=%08h -> result=%08h dbz=%0b latency=%0d",
               op, a, b, out_result, out_dbz, lat);
   endtask

   task automatic abort_test(input bit use_reset);
      bit    saw;
      string tag;
      tag = use_reset ? "reset-abort" : "flush-abort";
      in_valid = 1'b1;
      in_op    = 5'd15;
      in_src1  = 32'd100;
      in_src2  = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Now in BUSY cycle 1; move to BUSY cycle 10.
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      if (use_reset) reset = 1'b1;
      else flush = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      saw = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) saw = 1'b1;
      end
      chk({tag, " late valid"}, 32'(saw), 32'd0);
      @(posedge clk);
      #1;
      $display("%s: aborted DIV, out_valid seen afterwards=%0b", tag, saw);
      run_op({tag, " ADD"}, 5'd0, 32'd20, 32'd22, 32'd42, 1'b0);
   endtask

   initial begin : stim
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_op     = 5'd0;
      in_src1   = 32'd5;
      in_src2   = 32'd6;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      chk_en   = 1'b1;
      @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_result", out_result, 32'd0);
      chk("reset out_dbz", 32'(out_dbz), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      $display("reset: out_valid=%0b out_result=%08h in_ready=%0b", out_valid, out_result, in_ready);
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].dbz);
      end

      // Backpressure: result held 5 cycles, then consumed with a new ADD.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op     = 5'd0;
      in_src1   = 32'd3;
      in_src2   = 32'd4;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp valid", 32'(out_valid), 32'd1);
         chk("bp result", out_result, 32'd7);
         chk("bp in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = 5'd0;
      in_src1   = 32'd1;
      in_src2   = 32'd1;
      @(negedge clk);
      chk("bp release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp next valid", 32'(out_valid), 32'd1);
      chk("bp next result", out_result, 32'd2);
      $display("backpressure: held 7 for 5 cycles, next result=%08h", out_result);
      @(posedge clk);
      #1;

      // Back-to-back simple ops, one per cycle.
      in_valid = 1'b1;
      in_op    = 5'd0;
      in_src1  = 32'd1;
      in_src2  = 32'd2;
      @(posedge clk);
      #1;
      in_op    = 5'd1;
      in_src1  = 32'd10;
      in_src2  = 32'd3;
      @(negedge clk);
      chk("b2b add", out_result, 32'd3);
      @(posedge clk);
      #1;
      in_op    = 5'd7;
      in_src1  = 32'h000000F0;
      in_src2  = 32'h000000FF;
      @(negedge clk);
      chk("b2b sub", out_result, 32'd7);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b xor", out_result, 32'h0000000F);
      chk("b2b valid", 32'(out_valid), 32'd1);
      $display("back-to-back: last result=%08h", out_result);
      @(posedge clk);
      #1;

      // Flush in the same cycle as a request blocks acceptance.
      in_valid = 1'b1;
      flush    = 1'b1;
      in_op    = 5'd0;
      in_src1  = 32'd9;
      in_src2  = 32'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
      chk("flush blocks accept", 32'(out_valid), 32'd0);
      $display("flush+valid: out_valid=%0b", out_valid);
      @(posedge clk);
      #1;

      abort_test(1'b0);
      abort_test(1'b1);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
